// File: rtl/rv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv_pkg
// Description : Shared register-file types and constants for the write-back
//               controller and its load-destination FIFO.
//                 XLEN       - datapath width
//                 REG_AW     - register index width (32 architectural regs)
//                 REG_X0     - hard-wired zero register index
//                 reg_addr_t - register index type
//                 wb_src_e   - source of the registered write-port value
// Revision    : 1.0 - initial release
// ============================================================================
package rv_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef logic [REG_AW-1:0] reg_addr_t;

    localparam reg_addr_t REG_X0 = 5'd0;

    typedef enum logic [1:0] {
        WB_NONE = 2'd0,
        WB_ALU  = 2'd1,
        WB_LD   = 2'd2
    } wb_src_e;

    // True for any register that actually holds state (everything but x0).
    function automatic logic is_nz(input reg_addr_t a);
        return (a != REG_X0);
    endfunction

endpackage : rv_pkg
`default_nettype wire

// File: rtl/wb_ctrl_rd_fifo.sv
`default_nettype none
// ============================================================================
// Module      : rd_fifo
// Description : Synchronous FIFO of destination register indices, one entry
//               per outstanding load, popped in issue order as responses
//               return.
// Ports       :
//   clk         in   clock
//   rst         in   synchronous active-high reset (pointers/count cleared)
//   i_push      in   write i_push_addr at the tail
//   i_push_addr in   destination index of the newly issued load
//   i_pop       in   drop the head entry
//   o_full      out  DEPTH entries held
//   o_empty     out  no entries held
//   o_head      out  destination index of the oldest load
// Revision    : 1.0 - initial release
// ============================================================================
module rd_fifo
    import rv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      i_push,
    input  reg_addr_t i_push_addr,
    input  logic      i_pop,
    output logic      o_full,
    output logic      o_empty,
    output reg_addr_t o_head
);

    localparam int             c_PW       = $clog2(DEPTH);
    localparam logic [c_PW:0]  c_FULL_CNT = (c_PW+1)'(DEPTH);

    reg_addr_t           r_mem [DEPTH];
    logic [c_PW-1:0]     r_wr_ptr;
    logic [c_PW-1:0]     r_rd_ptr;
    logic [c_PW:0]       r_count;

    // Storage needs no reset: an entry is only read once count says it is live.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_addr;
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_full  = (r_count == c_FULL_CNT);
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rd_ptr];

    a_no_push_full : assert property (@(posedge clk) disable iff (rst)
        !(i_push && o_full));
    a_no_pop_empty : assert property (@(posedge clk) disable iff (rst)
        !(i_pop && o_empty));

endmodule : rd_fifo
`default_nettype wire

// File: rtl/wb_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : wb_ctrl
// Description : Register-file write-back controller. Merges single-cycle ALU
//               results and in-order load responses onto the one register
//               file write port, tracks destinations of outstanding loads in
//               a pending scoreboard and stalls issue on RAW/WAW hazards
//               against them.
// Ports       :
//   clk, rst               clock, synchronous active-high reset
//   i_issue_*              instruction presented by the issue stage
//   o_issue_stall          combinational: hold issue this cycle
//   i_alu_*                ALU result (fixed priority on the write port)
//   i_ld_rsp_valid/_data   load response, returns in issue order
//   o_ld_rsp_ready         load response consumed this cycle
//   o_rd_wr/_addr/_data    registered register-file write port
// Revision    : 1.0 - initial release
// ============================================================================
module wb_ctrl
    import rv_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int LDQ_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_issue_valid,
    input  logic [4:0]      i_issue_rs1_addr,
    input  logic [4:0]      i_issue_rs2_addr,
    input  logic [4:0]      i_issue_rd_addr,
    input  logic            i_issue_rd_wr,
    input  logic            i_issue_is_load,
    output logic            o_issue_stall,
    input  logic            i_alu_valid,
    input  logic [4:0]      i_alu_rd_addr,
    input  logic [XLEN-1:0] i_alu_rd_data,
    input  logic            i_ld_rsp_valid,
    input  logic [XLEN-1:0] i_ld_rsp_data,
    output logic            o_ld_rsp_ready,
    output logic            o_rd_wr,
    output logic [4:0]      o_rd_addr,
    output logic [XLEN-1:0] o_rd_data
);

    localparam int                 c_NREGS    = 2**REG_AW;
    localparam logic [c_NREGS-1:0] c_ONE_HOT0 = {{(c_NREGS-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [c_NREGS-1:0] r_pend;
    logic               r_rd_wr;
    reg_addr_t          r_rd_addr;
    logic [XLEN-1:0]    r_rd_data;
    wb_src_e            r_wb_src;

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic               w_q_full;
    logic               w_q_empty;
    reg_addr_t          w_q_head;
    logic               w_rs1_haz;
    logic               w_rs2_haz;
    logic               w_waw_haz;
    logic               w_full_haz;
    logic               w_stall;
    logic               w_issue_acc;
    logic               w_push;
    logic               w_alu_wr;
    logic               w_ld_ready;
    logic               w_ld_pop;
    logic [c_NREGS-1:0] w_pend_set;
    logic [c_NREGS-1:0] w_pend_clr;

    assign w_rs1_haz  = is_nz(i_issue_rs1_addr) & r_pend[i_issue_rs1_addr];
    assign w_rs2_haz  = is_nz(i_issue_rs2_addr) & r_pend[i_issue_rs2_addr];
    assign w_waw_haz  = i_issue_rd_wr & is_nz(i_issue_rd_addr) & r_pend[i_issue_rd_addr];
    // No credit for a pop in the same cycle: keeps stall off the response path.
    assign w_full_haz = i_issue_is_load & w_q_full;

    assign w_stall     = i_issue_valid & (w_rs1_haz | w_rs2_haz | w_waw_haz | w_full_haz);
    assign w_issue_acc = i_issue_valid & ~w_stall;
    // Loads to x0 are still queued so their responses stay matched in order.
    assign w_push      = w_issue_acc & i_issue_is_load;

    // An ALU write to x0 is a no-op and does not block the load path.
    assign w_alu_wr   = i_alu_valid & is_nz(i_alu_rd_addr);
    assign w_ld_ready = ~w_q_empty & ~w_alu_wr;
    assign w_ld_pop   = i_ld_rsp_valid & w_ld_ready;

    assign w_pend_set = (w_push & i_issue_rd_wr & is_nz(i_issue_rd_addr))
                        ? (c_ONE_HOT0 << i_issue_rd_addr) : '0;
    assign w_pend_clr = (w_ld_pop & is_nz(w_q_head))
                        ? (c_ONE_HOT0 << w_q_head) : '0;

    // ------------------------------------------------------------------
    // Outstanding-load destination queue
    // ------------------------------------------------------------------
    rd_fifo #(
        .DEPTH(LDQ_DEPTH)
    ) u_rd_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_addr (i_issue_rd_addr),
        .i_pop       (w_ld_pop),
        .o_full      (w_q_full),
        .o_empty     (w_q_empty),
        .o_head      (w_q_head)
    );

    // ------------------------------------------------------------------
    // Pending scoreboard. The bit clears on the edge that registers the
    // load write; the register file bypass covers the following cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend <= '0;
        end else begin
            r_pend <= (r_pend & ~w_pend_clr) | w_pend_set;
        end
    end

    // ------------------------------------------------------------------
    // Registered write port. Address/data hold when idle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_wr   <= 1'b0;
            r_rd_addr <= REG_X0;
            r_rd_data <= '0;
            r_wb_src  <= WB_NONE;
        end else if (w_alu_wr) begin
            r_rd_wr   <= 1'b1;
            r_rd_addr <= i_alu_rd_addr;
            r_rd_data <= i_alu_rd_data;
            r_wb_src  <= WB_ALU;
        end else if (w_ld_pop) begin
            r_rd_wr   <= is_nz(w_q_head);
            r_rd_addr <= w_q_head;
            r_rd_data <= i_ld_rsp_data;
            r_wb_src  <= WB_LD;
        end else begin
            r_rd_wr   <= 1'b0;
            r_wb_src  <= WB_NONE;
        end
    end

    assign o_issue_stall  = w_stall;
    assign o_ld_rsp_ready = w_ld_ready;
    assign o_rd_wr        = r_rd_wr;
    assign o_rd_addr      = r_rd_addr;
    assign o_rd_data      = r_rd_data;

    // ------------------------------------------------------------------
    // Simulation checks
    // ------------------------------------------------------------------
    // The WAW stall keeps a new load off any register still pending.
    a_no_set_clr_same : assert property (@(posedge clk) disable iff (rst)
        ((w_pend_set & w_pend_clr) == '0));
    a_no_wr_x0 : assert property (@(posedge clk) disable iff (rst)
        (r_rd_wr |-> is_nz(r_rd_addr)));
    a_src_consistent : assert property (@(posedge clk) disable iff (rst)
        ((r_wb_src == WB_NONE) |-> !r_rd_wr));

endmodule : wb_ctrl
`default_nettype wire

// File: tb/tb_wb_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_ctrl
// Description : Self-checking bench for wb_ctrl. A queue/array reference
//               model is compared against the DUT every cycle; directed
//               scenarios pin literal values, then randomized traffic runs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_ctrl;

    localparam int c_XLEN  = 32;
    localparam int c_DEPTH = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_issue_valid;
    logic [4:0]        i_issue_rs1_addr;
    logic [4:0]        i_issue_rs2_addr;
    logic [4:0]        i_issue_rd_addr;
    logic              i_issue_rd_wr;
    logic              i_issue_is_load;
    logic              o_issue_stall;
    logic              i_alu_valid;
    logic [4:0]        i_alu_rd_addr;
    logic [c_XLEN-1:0] i_alu_rd_data;
    logic              i_ld_rsp_valid;
    logic [c_XLEN-1:0] i_ld_rsp_data;
    logic              o_ld_rsp_ready;
    logic              o_rd_wr;
    logic [4:0]        o_rd_addr;
    logic [c_XLEN-1:0] o_rd_data;

    int n_tests = 0;
    int n_fail  = 0;

    wb_ctrl #(.XLEN(c_XLEN), .LDQ_DEPTH(c_DEPTH)) dut (
        .clk              (clk),
        .rst              (rst),
        .i_issue_valid    (i_issue_valid),
        .i_issue_rs1_addr (i_issue_rs1_addr),
        .i_issue_rs2_addr (i_issue_rs2_addr),
        .i_issue_rd_addr  (i_issue_rd_addr),
        .i_issue_rd_wr    (i_issue_rd_wr),
        .i_issue_is_load  (i_issue_is_load),
        .o_issue_stall    (o_issue_stall),
        .i_alu_valid      (i_alu_valid),
        .i_alu_rd_addr    (i_alu_rd_addr),
        .i_alu_rd_data    (i_alu_rd_data),
        .i_ld_rsp_valid   (i_ld_rsp_valid),
        .i_ld_rsp_data    (i_ld_rsp_data),
        .o_ld_rsp_ready   (o_ld_rsp_ready),
        .o_rd_wr          (o_rd_wr),
        .o_rd_addr        (o_rd_addr),
        .o_rd_data        (o_rd_data)
    );

    always #5 clk = ~clk;

    task automatic ck(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: list of outstanding load destinations in issue
    // order, a set of registers awaiting load data, and the expected
    // registered write-port contents.
    // ------------------------------------------------------------------
    int          q[$];
    logic [31:0] m_pend  = '0;
    bit          started = 1'b0;
    logic        exp_wr;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;

    function automatic bit m_stall();
        if (!i_issue_valid) return 1'b0;
        if (i_issue_rs1_addr != 0 && m_pend[i_issue_rs1_addr]) return 1'b1;
        if (i_issue_rs2_addr != 0 && m_pend[i_issue_rs2_addr]) return 1'b1;
        if (i_issue_rd_wr && i_issue_rd_addr != 0 && m_pend[i_issue_rd_addr]) return 1'b1;
        if (i_issue_is_load && q.size() == c_DEPTH) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_alu_write();
        return i_alu_valid && (i_alu_rd_addr != 0);
    endfunction

    function automatic bit m_ready();
        return (q.size() != 0) && !m_alu_write();
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            m_pend   <= '0;
            exp_wr   <= 1'b0;
            exp_addr <= '0;
            exp_data <= '0;
            started  <= 1'b1;
        end else begin
            bit  v_acc;
            bit  v_pop;
            int  v_head;
            v_acc = i_issue_valid && !m_stall();
            v_pop = i_ld_rsp_valid && m_ready();
            if (m_alu_write()) begin
                exp_wr   <= 1'b1;
                exp_addr <= i_alu_rd_addr;
                exp_data <= i_alu_rd_data;
            end else if (v_pop) begin
                v_head   = q.pop_front();
                exp_wr   <= (v_head != 0);
                exp_addr <= 5'(v_head);
                exp_data <= i_ld_rsp_data;
                if (v_head != 0) m_pend[v_head] <= 1'b0;
            end else begin
                exp_wr <= 1'b0;
            end
            if (v_acc && i_issue_is_load) begin
                q.push_back(int'(i_issue_rd_addr));
                if (i_issue_rd_wr && i_issue_rd_addr != 0) m_pend[i_issue_rd_addr] <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            ck("stall",   {31'b0, o_issue_stall},  {31'b0, m_stall()});
            ck("ready",   {31'b0, o_ld_rsp_ready}, {31'b0, m_ready()});
            ck("rd_wr",   {31'b0, o_rd_wr},        {31'b0, exp_wr});
            ck("rd_addr", {27'b0, o_rd_addr},      {27'b0, exp_addr});
            ck("rd_data", o_rd_data,               exp_data);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        i_issue_valid    = 1'b0;
        i_issue_rs1_addr = '0;
        i_issue_rs2_addr = '0;
        i_issue_rd_addr  = '0;
        i_issue_rd_wr    = 1'b0;
        i_issue_is_load  = 1'b0;
        i_alu_valid      = 1'b0;
        i_alu_rd_addr    = '0;
        i_alu_rd_data    = '0;
        i_ld_rsp_valid   = 1'b0;
        i_ld_rsp_data    = '0;
    endtask

    task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic rd_wr, input logic is_load);
        i_issue_valid    = 1'b1;
        i_issue_rs1_addr = rs1;
        i_issue_rs2_addr = rs2;
        i_issue_rd_addr  = rd;
        i_issue_rd_wr    = rd_wr;
        i_issue_is_load  = is_load;
    endtask

    task automatic no_issue();
        i_issue_valid   = 1'b0;
        i_issue_is_load = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        step();
        step();
        rst = 1'b0;
        #1;
        // Reset state
        ck("rst_wr",    {31'b0, o_rd_wr}, 32'd0);
        ck("rst_addr",  {27'b0, o_rd_addr}, 32'd0);
        ck("rst_data",  o_rd_data, 32'd0);
        ck("rst_ready", {31'b0, o_ld_rsp_ready}, 32'd0);

        // ALU write to x5, then ALU to x0 (suppressed, addr/data hold)
        i_alu_valid = 1'b1; i_alu_rd_addr = 5'd5; i_alu_rd_data = 32'h1234_5678;
        step();
        i_alu_rd_addr = 5'd0; i_alu_rd_data = 32'hFFFF_FFFF;
        #1;
        ck("alu_wr",   {31'b0, o_rd_wr}, 32'd1);
        ck("alu_addr", {27'b0, o_rd_addr}, 32'd5);
        ck("alu_data", o_rd_data, 32'h1234_5678);
        step();
        i_alu_valid = 1'b0;
        #1;
        ck("alu_x0_wr",   {31'b0, o_rd_wr}, 32'd0);
        ck("alu_x0_hold", o_rd_data, 32'h1234_5678);

        // Load x10, dependent add stalls until the response is written
        issue(5'd0, 5'd0, 5'd10, 1'b1, 1'b1);
        #1;
        ck("ld10_nostall", {31'b0, o_issue_stall}, 32'd0);
        step();
        issue(5'd10, 5'd0, 5'd11, 1'b1, 1'b0);
        #1;
        ck("raw_stall_a", {31'b0, o_issue_stall}, 32'd1);
        step();
        ck("raw_stall_b", {31'b0, o_issue_stall}, 32'd1);
        i_ld_rsp_valid = 1'b1; i_ld_rsp_data = 32'hDEAD_BEEF;
        #1;
        ck("raw_ready", {31'b0, o_ld_rsp_ready}, 32'd1);
        step();
        i_ld_rsp_valid = 1'b0;
        #1;
        ck("ld10_wr",   {31'b0, o_rd_wr}, 32'd1);
        ck("ld10_addr", {27'b0, o_rd_addr}, 32'd10);
        ck("ld10_data", o_rd_data, 32'hDEAD_BEEF);
        ck("raw_release", {31'b0, o_issue_stall}, 32'd0);
        step();
        idle();

        // Queue full: loads x3, x4, third load x5 waits for a slot
        issue(5'd0, 5'd0, 5'd3, 1'b1, 1'b1);
        step();
        issue(5'd0, 5'd0, 5'd4, 1'b1, 1'b1);
        step();
        issue(5'd0, 5'd0, 5'd5, 1'b1, 1'b1);
        #1;
        ck("full_stall", {31'b0, o_issue_stall}, 32'd1);
        i_ld_rsp_valid = 1'b1; i_ld_rsp_data = 32'h11;
        #1;
        ck("full_no_credit", {31'b0, o_issue_stall}, 32'd1);
        step();
        i_ld_rsp_data = 32'h22;
        #1;
        ck("x3_addr", {27'b0, o_rd_addr}, 32'd3);
        ck("x3_data", o_rd_data, 32'h11);
        ck("slot_free", {31'b0, o_issue_stall}, 32'd0);
        step();
        i_ld_rsp_valid = 1'b0;
        issue(5'd5, 5'd0, 5'd0, 1'b0, 1'b0);
        #1;
        ck("x4_addr", {27'b0, o_rd_addr}, 32'd4);
        ck("x4_data", o_rd_data, 32'h22);
        ck("x5_pending", {31'b0, o_issue_stall}, 32'd1);
        no_issue();
        i_ld_rsp_valid = 1'b1; i_ld_rsp_data = 32'h33;
        step();
        idle();

        // ALU and load response collide: ALU first, load data held
        issue(5'd0, 5'd0, 5'd12, 1'b1, 1'b1);
        step();
        no_issue();
        i_alu_valid = 1'b1; i_alu_rd_addr = 5'd7; i_alu_rd_data = 32'h77;
        i_ld_rsp_valid = 1'b1; i_ld_rsp_data = 32'hCC;
        #1;
        ck("collide_ready", {31'b0, o_ld_rsp_ready}, 32'd0);
        step();
        i_alu_valid = 1'b0;
        #1;
        ck("x7_addr", {27'b0, o_rd_addr}, 32'd7);
        ck("x7_data", o_rd_data, 32'h77);
        step();
        i_ld_rsp_valid = 1'b0;
        #1;
        ck("x12_addr", {27'b0, o_rd_addr}, 32'd12);
        ck("x12_data", o_rd_data, 32'hCC);
        idle();

        // Load to x0: consumed, no write
        issue(5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
        step();
        no_issue();
        i_ld_rsp_valid = 1'b1; i_ld_rsp_data = 32'h55;
        step();
        issue(5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        #1;
        ck("x0_wr",     {31'b0, o_rd_wr}, 32'd0);
        ck("x0_empty",  {31'b0, o_ld_rsp_ready}, 32'd0);
        ck("x0_nostall", {31'b0, o_issue_stall}, 32'd0);
        step();
        idle();

        // Reset with two loads outstanding
        issue(5'd0, 5'd0, 5'd1, 1'b1, 1'b1);
        step();
        issue(5'd0, 5'd0, 5'd2, 1'b1, 1'b1);
        step();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        i_ld_rsp_valid = 1'b1; i_ld_rsp_data = 32'h66;
        issue(5'd1, 5'd2, 5'd0, 1'b0, 1'b0);
        #1;
        ck("mrst_ready", {31'b0, o_ld_rsp_ready}, 32'd0);
        ck("mrst_wr",    {31'b0, o_rd_wr}, 32'd0);
        ck("mrst_stall", {31'b0, o_issue_stall}, 32'd0);
        step();
        idle();

        // WAW: non-load writer of x9 waits for the pending load to x9
        issue(5'd0, 5'd0, 5'd9, 1'b1, 1'b1);
        step();
        issue(5'd0, 5'd0, 5'd9, 1'b1, 1'b0);
        #1;
        ck("waw_stall", {31'b0, o_issue_stall}, 32'd1);
        i_ld_rsp_valid = 1'b1; i_ld_rsp_data = 32'h99;
        step();
        i_ld_rsp_valid = 1'b0;
        #1;
        ck("x9_addr", {27'b0, o_rd_addr}, 32'd9);
        ck("waw_release", {31'b0, o_issue_stall}, 32'd0);
        step();
        idle();

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            step();
            rst              = ($urandom_range(0, 299) == 0);
            i_issue_valid    = $urandom_range(0, 1) == 1;
            i_issue_rs1_addr = 5'($urandom_range(0, 7));
            i_issue_rs2_addr = 5'($urandom_range(0, 7));
            i_issue_rd_addr  = 5'($urandom_range(0, 7));
            i_issue_is_load  = $urandom_range(0, 9) < 4;
            i_issue_rd_wr    = i_issue_is_load ? 1'b1 : ($urandom_range(0, 3) != 0);
            i_alu_valid      = $urandom_range(0, 9) < 3;
            i_alu_rd_addr    = 5'($urandom_range(0, 31));
            i_alu_rd_data    = $urandom;
            i_ld_rsp_valid   = $urandom_range(0, 1) == 1;
            i_ld_rsp_data    = $urandom;
        end
        step();
        rst = 1'b0;
        idle();
        repeat (3) step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_wb_ctrl
`default_nettype wire
